// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and saturating branch/mispredict statistics. Lookup is combinational; updates are registered.
module branch_predictor_btb #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Flattened views of the per-entry state for the shared lookup/update decode
  logic [ENTRIES-1:0]             valid_all;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_all;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_all;
  logic [ENTRIES-1:0][CTR_W-1:0]  ctr_all;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  assign lk_idx  = lk_pc[IDX_W-1:0];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W];
  assign upd_hit = valid_all[upd_idx] && (tag_all[upd_idx] == upd_tag);

  assign lk_hit    = valid_all[lk_idx] && (tag_all[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ctr_all[lk_idx][CTR_W-1];
  assign lk_target = lk_hit ? target_all[lk_idx] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_q, valid_d;
      logic [TAG_W-1:0]  tag_q, tag_d;
      logic [ADDR_W-1:0] target_q, target_d;
      logic [CTR_W-1:0]  ctr_q, ctr_d;
      logic              wr_en;

      assign wr_en = upd_valid && (upd_idx == IDX_W'(gi));

      always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (wr_en) begin
          if (upd_hit) begin
            if (upd_taken) begin
              target_d = upd_target;
              if (ctr_q != CTR_MAX) ctr_d = ctr_q + CTR_W'(1);
            end else if (ctr_q != '0) begin
              ctr_d = ctr_q - CTR_W'(1);
            end
          end else if (upd_taken) begin
            // Allocation replaces whatever aliased entry lived at this index
            valid_d  = 1'b1;
            tag_d    = upd_tag;
            target_d = upd_target;
            ctr_d    = CTR_WEAK;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q  <= 1'b0;
          tag_q    <= '0;
          target_q <= '0;
          ctr_q    <= '0;
        end else begin
          valid_q  <= valid_d;
          tag_q    <= tag_d;
          target_q <= target_d;
          ctr_q    <= ctr_d;
        end
      end

      assign valid_all[gi]  = valid_q;
      assign tag_all[gi]    = tag_q;
      assign target_all[gi] = target_q;
      assign ctr_all[gi]    = ctr_q;
    end
  endgenerate

  logic [STAT_W-1:0] br_q, br_d;
  logic [STAT_W-1:0] mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (clr_stats) begin
      br_d = '0;
      mp_d = '0;
    end else if (upd_valid) begin
      if (br_q != STAT_MAX) br_d = br_q + STAT_W'(1);
      if ((upd_pred_taken != upd_taken) && (mp_q != STAT_MAX)) mp_d = mp_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed literal checks plus randomized traffic
// compared each cycle against an integer-array model of the BTB and its statistics.
module tb_branch_predictor_btb;
  localparam int ADDR_W  = 16;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int STAT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [ADDR_W-1:0] lk_pc = '0;
  logic              lk_hit, lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic              upd_pred_taken = 1'b0;
  logic              clr_stats = 1'b0;
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;

  branch_predictor_btb #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .lk_target(lk_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .clr_stats(clr_stats),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Model: one slot per index, counter as a plain integer 0..3
  int m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_target[ENTRIES];
  int m_ctr   [ENTRIES];
  int m_br, m_mp;
  int stat_max = (1 << STAT_W) - 1;
  int ctr_max  = (1 << CTR_W) - 1;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_update();
    int idx, tag;
    idx = int'(upd_pc) % ENTRIES;
    tag = int'(upd_pc) / ENTRIES;
    if (upd_valid) begin
      if (m_valid[idx] != 0 && m_tag[idx] == tag) begin
        if (upd_taken) begin
          m_ctr[idx]    = (m_ctr[idx] < ctr_max) ? m_ctr[idx] + 1 : ctr_max;
          m_target[idx] = int'(upd_target);
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[idx] = 1; m_tag[idx] = tag; m_target[idx] = int'(upd_target);
        m_ctr[idx] = (ctr_max + 1) / 2;
      end
    end
    if (clr_stats) begin
      m_br = 0;
      m_mp = 0;
    end else if (upd_valid) begin
      if (m_br < stat_max) m_br++;
      if (upd_pred_taken != upd_taken && m_mp < stat_max) m_mp++;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin : cmp
    int i;
    bit h;
    if (check_en) begin
      i = int'(lk_pc) % ENTRIES;
      h = (m_valid[i] != 0) && (m_tag[i] == int'(lk_pc) / ENTRIES);
      chk("cyc_lk_hit", int'(lk_hit), int'(h));
      chk("cyc_lk_taken", int'(lk_taken), int'(h && m_ctr[i] >= (ctr_max + 1) / 2));
      chk("cyc_lk_target", int'(lk_target), h ? m_target[i] : 0);
      chk("cyc_stat_branches", int'(stat_branches), m_br);
      chk("cyc_stat_mispredicts", int'(stat_mispredicts), m_mp);
      $display("cycle t=%0t lk_pc=%0h hit=%0d taken=%0d tgt=%0h br=%0d mp=%0d",
               $time, lk_pc, lk_hit, lk_taken, lk_target, stat_branches, stat_mispredicts);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_update();
  endtask

  task automatic step(input bit v, input int pc, input bit tk, input int tgt,
                      input bit pr, input bit clr, input int lk);
    tick();
    #1;
    upd_valid = v; upd_pc = ADDR_W'(pc); upd_taken = tk; upd_target = ADDR_W'(tgt);
    upd_pred_taken = pr; clr_stats = clr; lk_pc = ADDR_W'(lk);
    #1;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    model_reset();
    lk_pc = 16'h0003;
    #1;
    chk("reset_lk_hit", int'(lk_hit), 0);
    chk("reset_lk_taken", int'(lk_taken), 0);
    chk("reset_lk_target", int'(lk_target), 0);
    chk("reset_stat_branches", int'(stat_branches), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_en = 1'b1;

    // Allocate; same-cycle lookup still sees the empty entry
    step(1, 16'h0003, 1, 16'h0006, 0, 0, 16'h0003);
    chk("alloc_same_cycle_hit", int'(lk_hit), 0);
    step(1, 16'h0003, 1, 16'h0006, 1, 0, 16'h0003);
    chk("alloc_hit", int'(lk_hit), 1);
    chk("alloc_taken", int'(lk_taken), 1);
    chk("alloc_target", int'(lk_target), 16'h0006);
    chk("alloc_branches", int'(stat_branches), 1);
    chk("alloc_mispredicts", int'(stat_mispredicts), 1);
    // Hysteresis: ctr 2 -> 3 -> 3, then down 2, 1, 0, 0, then up to 1
    step(1, 16'h0003, 1, 16'h0006, 1, 0, 16'h0003);
    step(1, 16'h0003, 0, 0, 1, 0, 16'h0003);
    step(1, 16'h0003, 0, 0, 1, 0, 16'h0003);
    chk("hyst_ctr2_taken", int'(lk_taken), 1);
    step(1, 16'h0003, 0, 0, 0, 0, 16'h0003);
    chk("hyst_ctr1_taken", int'(lk_taken), 0);
    chk("hyst_ctr1_hit", int'(lk_hit), 1);
    step(1, 16'h0003, 0, 0, 0, 0, 16'h0003);
    step(1, 16'h0003, 1, 16'h0006, 0, 0, 16'h0003);
    step(0, 0, 0, 0, 0, 0, 16'h0003);
    chk("hyst_sat0_taken", int'(lk_taken), 0);
    chk("hyst_sat0_hit", int'(lk_hit), 1);
    chk("hyst_branches", int'(stat_branches), 8);
    chk("hyst_mispredicts", int'(stat_mispredicts), 4);

    // Aliasing
    step(0, 0, 0, 0, 0, 0, 16'h0013);
    chk("alias_lookup_miss", int'(lk_hit), 0);
    step(1, 16'h0013, 1, 16'h0020, 0, 0, 16'h0003);
    step(1, 16'h0025, 0, 0, 0, 0, 16'h0003);
    chk("alias_old_evicted", int'(lk_hit), 0);
    step(0, 0, 0, 0, 0, 0, 16'h0013);
    chk("alias_new_hit", int'(lk_hit), 1);
    chk("alias_new_target", int'(lk_target), 16'h0020);
    step(0, 0, 0, 0, 0, 0, 16'h0005);
    chk("nt_miss_no_alloc", int'(lk_hit), 0);

    // Same-cycle read/write, then clear together with an update
    step(1, 16'h0005, 1, 16'h0009, 0, 0, 16'h0005);
    chk("rw_same_cycle_hit", int'(lk_hit), 0);
    step(1, 16'h0013, 1, 16'h0020, 0, 1, 16'h0005);
    chk("rw_next_hit", int'(lk_hit), 1);
    chk("rw_next_target", int'(lk_target), 16'h0009);
    step(0, 0, 0, 0, 0, 0, 16'h0013);
    chk("clr_branches", int'(stat_branches), 0);
    chk("clr_mispredicts", int'(stat_mispredicts), 0);

    // Stat saturation at 4 bits
    for (int k = 0; k < 20; k++) step(1, 16'h0007, 1, 16'h0011, 0, 0, 16'h0013);
    step(0, 0, 0, 0, 0, 0, 16'h0003);
    chk("sat_branches", int'(stat_branches), 15);
    chk("sat_mispredicts", int'(stat_mispredicts), 15);

    // Asynchronous reset between edges
    step(0, 0, 0, 0, 0, 0, 16'h0013);
    chk("pre_reset_hit", int'(lk_hit), 1);
    tick();
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_lk_hit", int'(lk_hit), 0);
    chk("async_lk_target", int'(lk_target), 0);
    chk("async_branches", int'(stat_branches), 0);
    chk("async_mispredicts", int'(stat_mispredicts), 0);
    tick();
    #1 reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 16'h0003);
    chk("post_reset_miss", int'(lk_hit), 0);

    // Randomized traffic over a small PC window to force aliasing
    for (int n = 0; n < 3000; n++) begin
      int pc, lk;
      pc = int'($urandom_range(0, 63));
      lk = ($urandom_range(0, 3) == 0) ? pc : int'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, lk);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
